// File: rtl/md_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op encodings,
// FSM state type and the magnitude/negate helpers used when preparing operands and fixing results.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } mdState_e;

    // Helpers work on a fixed wide container; callers zero-extend in and truncate out,
    // which covers the 2*WIDTH product for WIDTH up to 64.
    localparam int MD_MAX_W = 128;
    typedef logic [MD_MAX_W-1:0] mdWide_t;

    function automatic mdWide_t mdNegate(input mdWide_t v);
        return ~v + mdWide_t'(1);
    endfunction

    function automatic mdWide_t mdMagnitude(input mdWide_t v, input logic isNeg);
        return isNeg ? mdNegate(v) : v;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the control FSM and the multiply/divide unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    import md_pkg::*;

    // start is sampled only while busy=0; op/a/b are captured with it. busy stays high
    // until the one-cycle done pulse, which arrives together with div0 and the new hi/lo.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    mdState_e         dbgState;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo, dbgState
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo, dbgState
    );

endinterface

// File: rtl/md_unit.sv
// Multicycle signed/unsigned multiply (shift-add) and divide (restoring) unit
// writing HI/LO; one iteration per cycle, WIDTH+2 cycles from start to done.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic       clock,
    input logic       reset,
    md_unit_if.slave  bus
);

    localparam int AW = 2 * WIDTH + 1;

    mdState_e state, nextState;

    logic [1:0]       opR;
    logic [WIDTH-1:0] aR, bR, operandR;
    logic [AW-1:0]    accR;
    logic [CNT_W-1:0] cntR;
    logic             negLoR, negHiR, divZeroR;
    logic             busyR, doneR, div0R;
    logic [WIDTH-1:0] hiR, loR;

    logic               isDiv, isSigned, aNeg, bNeg, bZero, lastIter;
    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH:0]     mulUpper;
    logic [AW-1:0]      mulNext, divShift, divNext;
    logic [WIDTH+1:0]   divDiff;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;

    always_comb begin
        isDiv    = opR[1];
        isSigned = ~opR[0];
        aNeg     = isSigned & aR[WIDTH-1];
        bNeg     = isSigned & bR[WIDTH-1];
        magA     = WIDTH'(mdMagnitude(mdWide_t'(aR), aNeg));
        magB     = WIDTH'(mdMagnitude(mdWide_t'(bR), bNeg));
        bZero    = (bR == '0);
        lastIter = (cntR == CNT_W'(WIDTH - 1));

        // Multiply: multiplier sits in the low half and is consumed from bit 0.
        mulUpper = accR[AW-1:WIDTH] + (accR[0] ? {1'b0, operandR} : '0);
        mulNext  = {1'b0, mulUpper, accR[WIDTH-1:1]};

        // Divide: the extra top bit keeps the shifted partial remainder intact.
        divShift = {accR[AW-2:0], 1'b0};
        divDiff  = {1'b0, divShift[AW-1:WIDTH]} - {2'b0, operandR};
        divNext  = divDiff[WIDTH+1] ? divShift
                                    : {divDiff[WIDTH:0], divShift[WIDTH-1:1], 1'b1};

        prodFix = negLoR ? (2*WIDTH)'(mdNegate(mdWide_t'(accR[2*WIDTH-1:0])))
                         : accR[2*WIDTH-1:0];
        quotFix = negLoR ? WIDTH'(mdNegate(mdWide_t'(accR[WIDTH-1:0])))
                         : accR[WIDTH-1:0];
        remFix  = negHiR ? WIDTH'(mdNegate(mdWide_t'(accR[2*WIDTH-1:WIDTH])))
                         : accR[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A zero divisor still passes through FIX so done lands on the cycle the
    // control FSM expects, with hi/lo left untouched.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (bus.start) nextState = PREP;
            PREP: nextState = (isDiv && bZero) ? FIX : RUN;
            RUN:  if (lastIter) nextState = FIX;
            FIX:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opR      <= '0;
            aR       <= '0;
            bR       <= '0;
            operandR <= '0;
            accR     <= '0;
            cntR     <= '0;
            negLoR   <= 1'b0;
            negHiR   <= 1'b0;
            divZeroR <= 1'b0;
            hiR      <= '0;
            loR      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        opR <= bus.op;
                        aR  <= bus.a;
                        bR  <= bus.b;
                    end
                end
                PREP: begin
                    operandR <= isDiv ? magB : magA;
                    accR     <= {{(WIDTH + 1){1'b0}}, (isDiv ? magA : magB)};
                    cntR     <= '0;
                    negLoR   <= aNeg ^ bNeg;
                    negHiR   <= aNeg;
                    divZeroR <= isDiv & bZero;
                end
                RUN: begin
                    accR <= isDiv ? divNext : mulNext;
                    cntR <= cntR + CNT_W'(1);
                end
                FIX: begin
                    if (!divZeroR) begin
                        hiR <= isDiv ? remFix  : prodFix[2*WIDTH-1:WIDTH];
                        loR <= isDiv ? quotFix : prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busyR <= 1'b0;
            doneR <= 1'b0;
            div0R <= 1'b0;
        end else begin
            busyR <= (nextState != IDLE);
            doneR <= (state == FIX);
            div0R <= (state == FIX) & divZeroR;
        end
    end

    assign bus.busy     = busyR;
    assign bus.done     = doneR;
    assign bus.div0     = div0R;
    assign bus.hi       = hiR;
    assign bus.lo       = loR;
    assign bus.dbgState = state;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios plus randomized ops checked against
// a plain-arithmetic reference model through an expected-result queue.
module tb_md_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    md_unit_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [2*W:0] exp_q[$];
    logic [W-1:0] shownHi = '0;
    logic [W-1:0] shownLo = '0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result as {div0, hi, lo}, straight from the arithmetic rules.
    function automatic logic [2*W:0] refModel(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] pHi,
                                              input logic [W-1:0] pLo);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [2*W-1:0]  p;
        logic [W-1:0]    q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        q  = '0;
        r  = '0;
        case (op)
            MD_MULT:  p = sa * sb;
            MD_MULTU: p = ua * ub;
            MD_DIV: begin
                if (b == 0) return {1'b1, pHi, pLo};
                q = W'(sa / sb);
                r = W'(sa % sb);
                p = {r, q};
            end
            default: begin
                if (b == 0) return {1'b1, pHi, pLo};
                q = W'(ua / ub);
                r = W'(ua % ub);
                p = {r, q};
            end
        endcase
        return {1'b0, p};
    endfunction

    // Called #1 after a rising edge; the next rising edge samples start.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        exp_q.push_back(refModel(op, a, b, shownHi, shownLo));
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        checkEq("busy_after_start", bus.busy, 1);
    endtask

    // skipped = cycles already elapsed since the accepting edge.
    task automatic waitDone(input int skipped);
        int           k;
        int           expLat;
        logic [2*W:0] exp;
        k = 0;
        exp = '0;
        checkEq("exp_queue_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        expLat = (exp[2*W] ? 2 : W + 2) - skipped;
        do begin
            @(posedge clock);
            #1;
            k++;
            if (bus.done !== 1'b1) begin
                checkEq("hold_hi", bus.hi, shownHi);
                checkEq("hold_lo", bus.lo, shownLo);
            end
        end while (bus.done !== 1'b1 && k < 60);
        checkEq("latency", k, expLat);
        checkEq("div0", bus.div0, exp[2*W]);
        checkEq("hi", bus.hi, exp[2*W-1:W]);
        checkEq("lo", bus.lo, exp[W-1:0]);
        checkEq("busy_at_done", bus.busy, 0);
        shownHi = exp[2*W-1:W];
        shownLo = exp[W-1:0];
    endtask

    task automatic idleCycle();
        @(posedge clock);
        #1;
        checkEq("done_drop", bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clock);
        #1;
        checkEq("rst_busy", bus.busy, 0);
        checkEq("rst_done", bus.done, 0);
        checkEq("rst_div0", bus.div0, 0);
        checkEq("rst_hi", bus.hi, 0);
        checkEq("rst_lo", bus.lo, 0);
        checkEq("rst_state", bus.dbgState, IDLE);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Signed multiply by a negative operand.
        issue(MD_MULT, 32'hFFFFFFFD, 32'h00000007);
        waitDone(0);
        checkEq("t1_hi", bus.hi, 32'hFFFFFFFF);
        checkEq("t1_lo", bus.lo, 32'hFFFFFFEB);
        idleCycle();

        // Max unsigned product, then a divide issued in the done cycle.
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(0);
        checkEq("t2_hi", bus.hi, 32'hFFFFFFFE);
        checkEq("t2_lo", bus.lo, 32'h00000001);
        issue(MD_DIVU, 32'd100, 32'd7);
        waitDone(0);
        checkEq("t2b_lo", bus.lo, 32'h0000000E);
        checkEq("t2b_hi", bus.hi, 32'h00000002);
        idleCycle();

        // Signed divide truncation and the most-negative / -1 wrap.
        issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
        waitDone(0);
        checkEq("t3_lo", bus.lo, 32'hFFFFFFFD);
        checkEq("t3_hi", bus.hi, 32'hFFFFFFFF);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitDone(0);
        checkEq("t3b_lo", bus.lo, 32'h80000000);
        checkEq("t3b_hi", bus.hi, 32'h00000000);
        idleCycle();

        // Divide by zero keeps the previous hi/lo.
        issue(MD_DIVU, 32'h56781234, 32'h00010000);
        waitDone(0);
        issue(MD_DIVU, 32'h00000064, 32'h00000000);
        waitDone(0);
        checkEq("t4_div0", bus.div0, 1);
        checkEq("t4_hi", bus.hi, 32'h00001234);
        checkEq("t4_lo", bus.lo, 32'h00005678);
        idleCycle();

        // start while busy must be ignored.
        issue(MD_MULTU, 32'h00012345, 32'h00006789);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        bus.op    = MD_DIV;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        checkEq("t5_busy", bus.busy, 1);
        waitDone(6);
        idleCycle();

        // Reset in the middle of RUN aborts without a done pulse.
        issue(MD_MULT, $urandom, $urandom);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        checkEq("t6_busy", bus.busy, 0);
        checkEq("t6_hi", bus.hi, 0);
        checkEq("t6_lo", bus.lo, 0);
        checkEq("t6_state", bus.dbgState, IDLE);
        exp_q.delete();
        shownHi = '0;
        shownLo = '0;
        repeat (3) begin
            @(posedge clock);
            #1;
            checkEq("t6_no_done", bus.done, 0);
        end
        reset = 1'b1;
        idleCycle();
        issue(MD_MULTU, 32'd3, 32'd5);
        waitDone(0);
        checkEq("t6_lo", bus.lo, 32'h0000000F);
        idleCycle();

        // Randomized ops with corner operands mixed in; some back-to-back.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
            waitDone(0);
            if ($urandom_range(0, 1) == 1) begin
                idleCycle();
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
